axis_route_cfg_sched: RTL and testbench
=======================================

Name: axis_route_cfg_sched

Overview:
- Sequences route updates for the per-region vFPGA data switch. Configuration writes arrive on one shared request port.
- Each update is held per region and applied to that region's route word only at a packet boundary, when both the host and DTU sink streams of the region are quiescent. This keeps tdest from changing mid-packet or under a pending beat.
- Sits between the control/register path and the switch `route_in` input.
- Per region it exports: a hold request (upstream withholds new packet starts), a done pulse and a sticky drain-timeout flag.

Parameters:
- N_ID, N_REGIONS, number of regions/slots.
- TIMEOUT_CYCLES, 4096, drain cycles before timeout flag; 0 disables timeout.
- DEFAULT_ROUTE, 8'h00, reset value of every route word.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cfg_valid  in  1  route write request
- cfg_ready  out  1  request accepted when valid&ready
- cfg_region  in  $clog2(N_ID) (min 1)  target region
- cfg_route  in  8  new route word; [1:0] host tdest, [3:2] dtu tdest, [7:4] must be 0
- cfg_err  out  1  one-cycle pulse: request rejected
- host_tvalid, host_tready, host_tlast  in  N_ID each  host sink handshake taps
- dtu_tvalid, dtu_tready, dtu_tlast  in  N_ID each  DTU sink handshake taps
- route_out  out  N_ID x 8  registered route words to switch
- hold  out  N_ID  region has an update pending; upstream must not start new packets
- upd_done  out  N_ID  one-cycle pulse when a route word is updated
- err_timeout  out  N_ID  sticky drain timeout
- err_clr  in  N_ID  clears err_timeout[i]

Behaviour:
- Reset (async, aresetn=0) values:
  - route_out[i]=DEFAULT_ROUTE; all slots IDLE.
  - hold=0, upd_done=0, err_timeout=0, cfg_err=0.
  - In-flight flags and counters are 0.
  - Reset mid-drain discards the pending update.
- In-flight tracking, per stream s in {host,dtu}, region i:
  - Set on tvalid&tready&!tlast; cleared on tvalid&tready&tlast.
  - Single-beat packet: flag stays 0.
- quiet[i] = !host_inflight[i] & !host_tvalid[i] & !dtu_inflight[i] & !dtu_tvalid[i], using the current-cycle tvalid.
- cfg_ready = slot[cfg_region] is IDLE (combinational on cfg_region).
- cfg_region >= N_ID: cfg_ready=1, request consumed, cfg_err pulses the next cycle, no state change.
- cfg_route[7:4]!=0: same treatment as cfg_region >= N_ID (consumed, cfg_err next cycle, no state change).
- Slot FSM per region:
  - IDLE: a legal accept at cycle T latches pend_route and moves to DRAIN. hold[i]=1 from T+1.
  - DRAIN, quiet[i]=1: load route_out[i] <= pend_route and go to IDLE. route_out[i] and upd_done[i] are visible the next cycle, hold[i] drops that same cycle. Minimum latency: accept at T, new route at T+2.
  - DRAIN, quiet[i]=0: increment the drain counter, saturating.
  - When the counter reaches TIMEOUT_CYCLES (nonzero), set err_timeout[i]. The slot stays in DRAIN and still applies the update when quiet.
  - Counter clears on entering DRAIN.
- Writing the same route as current still passes through DRAIN and pulses upd_done.
- tlast beat and quiet:
  - The cycle of the tlast beat is not quiet (tvalid=1).
  - The following cycle is quiet only if tvalid=0. A back-to-back packet start (tvalid=1) defers the apply.
- err_clr[i] and a timeout set in the same cycle: set wins.
- Slots are independent; different regions may drain concurrently. Only one cfg accept is possible per cycle.

Decomposition:
- Shared package lynxTypes:
  - ROUTE_BITS=8.
  - Field offsets/widths: ROUTE_HOST_LSB=0, ROUTE_DTU_LSB=2, ROUTE_DEST_BITS=2.
  - Slot state enum: IDLE, DRAIN.
- One sub-module, route_cfg_slot, instantiated N_ID times. It contains:
  - the in-flight trackers
  - the FSM
  - the timeout counter
  - the route register
  - the err flag.
- The top holds cfg decode, cfg_ready mux and cfg_err.

Test Plan:
- Reset: route_out all 8'h00, hold=0. Idle write of region1=8'h06 at T: cfg_ready=1, hold[1]=1 at T+1, route_out[1]=8'h06 and upd_done[1] pulse at T+2, hold[1]=0 at T+2.
- Mid-packet: host[0] 4-beat packet, beat 2 accepted, then write region0=8'h09. route_out[0] unchanged until the cycle after the tlast beat with tvalid low. A second write to region0 during drain sees cfg_ready=0.
- Back-to-back: dtu[2] sends tlast and the next packet's first beat consecutively. The apply waits until tvalid=0. A single-beat packet (tlast on first beat) leaves the in-flight flag at 0.
- Timeout: TIMEOUT_CYCLES=16, host[0] held tvalid=1, tready=0. err_timeout[0]=1 after 16 drain cycles. Releasing the stream then applies the route. err_clr[0] clears the flag.
- Illegal: cfg_route=8'h13 or cfg_region=3 (N_ID=3). Request is consumed, cfg_err pulses once, route_out unchanged, no hold.
- Async reset asserted while region2 is draining: hold[2] and route_out[2] return to reset values immediately. No upd_done after release.

Source files
------------

// File: rtl/axis_route_cfg_sched_pkg.sv
// rtl/axis_route_cfg_sched_pkg.sv - shared route word layout and slot state types
package lynxTypes;

    localparam int ROUTE_BITS      = 8;
    localparam int ROUTE_HOST_LSB  = 0;
    localparam int ROUTE_DTU_LSB   = 2;
    localparam int ROUTE_DEST_BITS = 2;

    typedef enum logic [0:0] {
        SLOT_IDLE  = 1'b0,
        SLOT_DRAIN = 1'b1
    } slot_state_e;

    // Only the two tdest fields may be populated; upper bits are reserved.
    function automatic logic route_legal(input logic [ROUTE_BITS-1:0] r);
        return r[ROUTE_BITS-1:ROUTE_DTU_LSB+ROUTE_DEST_BITS] == '0;
    endfunction

endpackage

// File: rtl/axis_route_cfg_sched_slot.sv
// rtl/axis_route_cfg_sched_slot.sv - per-region route holder applying updates at packet boundaries
module route_cfg_slot
    import lynxTypes::*;
#(
    parameter int                    TIMEOUT_CYCLES = 4096,
    parameter logic [ROUTE_BITS-1:0] DEFAULT_ROUTE  = 8'h00
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  host_tvalid,
    input  logic                  host_tready,
    input  logic                  host_tlast,
    input  logic                  dtu_tvalid,
    input  logic                  dtu_tready,
    input  logic                  dtu_tlast,
    input  logic                  wr_en,
    input  logic [ROUTE_BITS-1:0] wr_route,
    input  logic                  err_clr,
    output logic                  idle,
    output logic [ROUTE_BITS-1:0] route,
    output logic                  hold,
    output logic                  upd_done,
    output logic                  err_timeout
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CNT_MAX - 1);

    slot_state_e           state;
    logic [ROUTE_BITS-1:0] pend_route;
    logic [CNT_W-1:0]      drain_cnt;
    logic                  host_inflight;
    logic                  dtu_inflight;
    logic                  quiet;
    logic                  timeout_hit;

    // Current-cycle tvalid counts, so a back-to-back packet start blocks the apply.
    assign quiet = !host_inflight && !host_tvalid && !dtu_inflight && !dtu_tvalid;
    assign idle  = (state == SLOT_IDLE);
    assign hold  = (state == SLOT_DRAIN);

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == SLOT_DRAIN) && !quiet
                         && (drain_cnt == CNT_PRE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            host_inflight <= 1'b0;
            dtu_inflight  <= 1'b0;
        end else begin
            if (host_tvalid && host_tready) host_inflight <= !host_tlast;
            if (dtu_tvalid && dtu_tready)   dtu_inflight  <= !dtu_tlast;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= SLOT_IDLE;
            pend_route <= DEFAULT_ROUTE;
            route      <= DEFAULT_ROUTE;
            drain_cnt  <= '0;
            upd_done   <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            case (state)
                SLOT_IDLE: begin
                    if (wr_en) begin
                        pend_route <= wr_route;
                        drain_cnt  <= '0;
                        state      <= SLOT_DRAIN;
                    end
                end
                SLOT_DRAIN: begin
                    if (quiet) begin
                        route    <= pend_route;
                        upd_done <= 1'b1;
                        state    <= SLOT_IDLE;
                    end else if (drain_cnt != CNT_TOP) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= SLOT_IDLE;
            endcase
        end
    end

    // A timeout landing in the same cycle as a clear takes priority.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_timeout <= 1'b0;
        end else if (timeout_hit) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_route_cfg_sched.sv
// rtl/axis_route_cfg_sched.sv - route update sequencer for the per-region vFPGA data switch
module axis_route_cfg_sched
    import lynxTypes::*;
#(
    parameter int                    N_ID           = 3,
    parameter int                    TIMEOUT_CYCLES = 4096,
    parameter logic [ROUTE_BITS-1:0] DEFAULT_ROUTE  = 8'h00,
    localparam int                   REG_W          = (N_ID > 1) ? $clog2(N_ID) : 1
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [REG_W-1:0]                    cfg_region,
    input  logic [ROUTE_BITS-1:0]               cfg_route,
    output logic                                cfg_err,
    input  logic [N_ID-1:0]                     host_tvalid,
    input  logic [N_ID-1:0]                     host_tready,
    input  logic [N_ID-1:0]                     host_tlast,
    input  logic [N_ID-1:0]                     dtu_tvalid,
    input  logic [N_ID-1:0]                     dtu_tready,
    input  logic [N_ID-1:0]                     dtu_tlast,
    output logic [N_ID-1:0][ROUTE_BITS-1:0]     route_out,
    output logic [N_ID-1:0]                     hold,
    output logic [N_ID-1:0]                     upd_done,
    output logic [N_ID-1:0]                     err_timeout,
    input  logic [N_ID-1:0]                     err_clr
);

    logic [N_ID-1:0] slot_idle;
    logic [N_ID-1:0] wr_en;
    logic            region_ok;
    logic            legal;
    logic            ready_sel;

    // Illegal requests are always consumed so a bad write cannot stall the port.
    always_comb begin
        region_ok = 1'b0;
        ready_sel = 1'b1;
        wr_en     = '0;
        for (int i = 0; i < N_ID; i++) begin
            if (cfg_region == REG_W'(i)) begin
                region_ok = 1'b1;
                ready_sel = slot_idle[i];
            end
        end
        legal     = region_ok && route_legal(cfg_route);
        cfg_ready = legal ? ready_sel : 1'b1;
        for (int i = 0; i < N_ID; i++) begin
            wr_en[i] = cfg_valid && legal && slot_idle[i] && (cfg_region == REG_W'(i));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cfg_err <= 1'b0;
        else          cfg_err <= cfg_valid && !legal;
    end

    for (genvar g = 0; g < N_ID; g++) begin : g_slot
        route_cfg_slot #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .DEFAULT_ROUTE  (DEFAULT_ROUTE)
        ) u_slot (
            .aclk        (aclk),
            .aresetn     (aresetn),
            .host_tvalid (host_tvalid[g]),
            .host_tready (host_tready[g]),
            .host_tlast  (host_tlast[g]),
            .dtu_tvalid  (dtu_tvalid[g]),
            .dtu_tready  (dtu_tready[g]),
            .dtu_tlast   (dtu_tlast[g]),
            .wr_en       (wr_en[g]),
            .wr_route    (cfg_route),
            .err_clr     (err_clr[g]),
            .idle        (slot_idle[g]),
            .route       (route_out[g]),
            .hold        (hold[g]),
            .upd_done    (upd_done[g]),
            .err_timeout (err_timeout[g])
        );
    end

endmodule

// File: tb/tb_axis_route_cfg_sched.sv
// tb/tb_axis_route_cfg_sched.sv - directed self-checking bench for axis_route_cfg_sched
module tb_axis_route_cfg_sched;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_region;
    logic [7:0]      cfg_route;
    logic            cfg_err;
    logic [2:0]      host_tvalid, host_tready, host_tlast;
    logic [2:0]      dtu_tvalid, dtu_tready, dtu_tlast;
    logic [2:0][7:0] route_out;
    logic [2:0]      hold, upd_done, err_timeout, err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    axis_route_cfg_sched #(
        .N_ID           (3),
        .TIMEOUT_CYCLES (16),
        .DEFAULT_ROUTE  (8'h00)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_region  (cfg_region),
        .cfg_route   (cfg_route),
        .cfg_err     (cfg_err),
        .host_tvalid (host_tvalid),
        .host_tready (host_tready),
        .host_tlast  (host_tlast),
        .dtu_tvalid  (dtu_tvalid),
        .dtu_tready  (dtu_tready),
        .dtu_tlast   (dtu_tlast),
        .route_out   (route_out),
        .hold        (hold),
        .upd_done    (upd_done),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic cfg_req(input logic [1:0] region, input logic [7:0] route);
        cfg_valid  = 1'b1;
        cfg_region = region;
        cfg_route  = route;
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        cfg_valid = 0; cfg_region = 0; cfg_route = 0;
        host_tvalid = 0; host_tready = 0; host_tlast = 0;
        dtu_tvalid = 0; dtu_tready = 0; dtu_tlast = 0;
        err_clr = 0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        check_eq("rst_route", route_out, 24'h0);
        check_eq("rst_hold", hold, 3'b000);
        check_eq("rst_done", upd_done, 3'b000);
        check_eq("rst_err", err_timeout, 3'b000);
        check_eq("rst_cfg_err", cfg_err, 1'b0);

        // idle write region1 = 06
        cfg_req(2'd1, 8'h06);
        check_eq("idle_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 0;
        check_eq("idle_hold_t1", hold, 3'b010);
        check_eq("idle_route_t1", route_out[1], 8'h00);
        tick();
        check_eq("idle_route_t2", route_out[1], 8'h06);
        check_eq("idle_done_t2", upd_done, 3'b010);
        check_eq("idle_hold_t2", hold, 3'b000);
        tick();
        check_eq("idle_done_t3", upd_done, 3'b000);

        // mid-packet host[0]: 4 beats with a gap after beat 2
        host_tready[0] = 1; host_tvalid[0] = 1; host_tlast[0] = 0;
        tick(); tick();
        host_tvalid[0] = 0;
        cfg_req(2'd0, 8'h09);
        tick();
        check_eq("mid_hold", hold[0], 1'b1);
        cfg_req(2'd0, 8'h0A);
        check_eq("mid_busy_ready", cfg_ready, 1'b0);
        tick();
        cfg_valid = 0;
        check_eq("mid_route_gap", route_out[0], 8'h00);
        host_tvalid[0] = 1;
        tick();
        host_tlast[0] = 1;
        tick();
        host_tvalid[0] = 0; host_tlast[0] = 0;
        check_eq("mid_route_after_last", route_out[0], 8'h00);
        check_eq("mid_hold_after_last", hold[0], 1'b1);
        tick();
        check_eq("mid_route_applied", route_out[0], 8'h09);
        check_eq("mid_done", upd_done, 3'b001);
        check_eq("mid_hold_drop", hold[0], 1'b0);

        // back-to-back dtu[2]
        dtu_tready[2] = 1; dtu_tvalid[2] = 1; dtu_tlast[2] = 0;
        tick();
        dtu_tlast[2] = 1;
        cfg_req(2'd2, 8'h0C);
        tick();
        cfg_valid = 0;
        dtu_tlast[2] = 0;
        tick();
        dtu_tlast[2] = 1;
        check_eq("b2b_hold", hold[2], 1'b1);
        check_eq("b2b_route_wait", route_out[2], 8'h00);
        tick();
        dtu_tvalid[2] = 0; dtu_tlast[2] = 0;
        check_eq("b2b_route_wait2", route_out[2], 8'h00);
        tick();
        check_eq("b2b_route_applied", route_out[2], 8'h0C);
        check_eq("b2b_done", upd_done, 3'b100);

        // single-beat packet keeps in-flight clear
        dtu_tvalid[2] = 1; dtu_tlast[2] = 1;
        tick();
        dtu_tvalid[2] = 0; dtu_tlast[2] = 0;
        cfg_req(2'd2, 8'h04);
        tick();
        cfg_valid = 0;
        tick();
        check_eq("single_route", route_out[2], 8'h04);
        check_eq("single_done", upd_done, 3'b100);

        // drain timeout on host[0]
        host_tvalid[0] = 1; host_tready[0] = 0;
        cfg_req(2'd0, 8'h05);
        tick();
        cfg_valid = 0;
        repeat (15) tick();
        check_eq("to_not_yet", err_timeout, 3'b000);
        tick();
        check_eq("to_set", err_timeout, 3'b001);
        check_eq("to_route_held", route_out[0], 8'h09);
        host_tvalid[0] = 0;
        tick();
        check_eq("to_route_applied", route_out[0], 8'h05);
        check_eq("to_sticky", err_timeout, 3'b001);
        err_clr[0] = 1;
        tick();
        err_clr[0] = 0;
        check_eq("to_cleared", err_timeout, 3'b000);

        // illegal route bits
        cfg_req(2'd0, 8'h13);
        check_eq("ill_route_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 0;
        check_eq("ill_route_err", cfg_err, 1'b1);
        check_eq("ill_route_hold", hold, 3'b000);
        tick();
        check_eq("ill_route_err_once", cfg_err, 1'b0);
        check_eq("ill_route_unchanged", route_out, 24'h04_06_05);

        // illegal region
        cfg_req(2'd3, 8'h01);
        check_eq("ill_reg_ready", cfg_ready, 1'b1);
        tick();
        cfg_valid = 0;
        check_eq("ill_reg_err", cfg_err, 1'b1);
        check_eq("ill_reg_hold", hold, 3'b000);
        tick();
        check_eq("ill_reg_err_once", cfg_err, 1'b0);
        check_eq("ill_reg_unchanged", route_out, 24'h04_06_05);

        // async reset while region2 drains
        dtu_tvalid[2] = 1; dtu_tready[2] = 0;
        cfg_req(2'd2, 8'h08);
        tick();
        cfg_valid = 0;
        check_eq("ar_hold_before", hold[2], 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check_eq("ar_hold_now", hold, 3'b000);
        check_eq("ar_route_now", route_out, 24'h0);
        dtu_tvalid[2] = 0;
        tick();
        aresetn = 1'b1;
        tick();
        check_eq("ar_no_done1", upd_done, 3'b000);
        tick();
        check_eq("ar_no_done2", upd_done, 3'b000);
        check_eq("ar_route_after", route_out[2], 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
